// File: rtl/gpu_ctrl_pkg.sv
// Shared constants, types and helpers for the GPU framebuffer control slave.
// Register offsets are word indices taken from address bits [4:2].
package gpu_ctrl_pkg;

  localparam logic [2:0] ADDR_CTRL        = 3'd0;
  localparam logic [2:0] ADDR_STATUS      = 3'd1;
  localparam logic [2:0] ADDR_PIXEL_ADDR  = 3'd2;
  localparam logic [2:0] ADDR_PIXEL_DATA  = 3'd3;
  localparam logic [2:0] ADDR_FILL_COUNT  = 3'd4;
  localparam logic [2:0] ADDR_FILL_COLOR  = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_FILL_START_BIT = 0;
  localparam int unsigned CTRL_AUTO_INC_BIT   = 1;
  localparam int unsigned STATUS_BUSY_BIT     = 0;
  localparam int unsigned STATUS_ERR_BIT      = 1;

  typedef enum logic {
    StIdle,
    StFill
  } fill_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpu_fill_engine.sv
// Fill FSM and framebuffer write-port driver: single-pixel writes arrive as a one-cycle pulse,
// fills stream one constant colour per clock with address wrap at FBUF_DEPTH.
module gpu_fill_engine
  import gpu_ctrl_pkg::*;
#(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned FBUF_DEPTH      = 307200
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_fill_start,
  input  logic                       i_pix_wr,
  input  logic                       i_auto_inc,
  input  logic [FBUF_ADDR_WIDTH-1:0] i_pixel_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] i_pixel_data,
  input  logic [FBUF_DATA_WIDTH-1:0] i_fill_color,
  input  logic [FBUF_ADDR_WIDTH:0]   i_fill_count,
  output logic                       o_busy,
  output logic                       o_addr_upd,
  output logic [FBUF_ADDR_WIDTH-1:0] o_addr_new,
  output logic                       o_fbuf_en,
  output logic                       o_fbuf_we,
  output logic [FBUF_ADDR_WIDTH-1:0] o_fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] o_fbuf_data
);

  localparam int unsigned AW = FBUF_ADDR_WIDTH;
  localparam int unsigned CW = FBUF_ADDR_WIDTH + 1;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if (a == AW'(FBUF_DEPTH - 1)) begin
      return '0;
    end
    return a + AW'(1);
  endfunction

  fill_state_e          r_state, w_state_next;
  logic [AW-1:0]        r_cur_addr, w_cur_addr_next;
  logic [CW-1:0]        r_remaining, w_remaining_next;
  logic                 w_wr;
  logic [AW-1:0]        w_wr_addr;
  logic [FBUF_DATA_WIDTH-1:0] w_wr_data;
  logic                 r_fbuf_en;
  logic [AW-1:0]        r_fbuf_addr;
  logic [FBUF_DATA_WIDTH-1:0] r_fbuf_data;

  always_comb begin
    w_state_next     = r_state;
    w_cur_addr_next  = r_cur_addr;
    w_remaining_next = r_remaining;
    w_wr             = 1'b0;
    w_wr_addr        = r_cur_addr;
    w_wr_data        = i_fill_color;
    o_addr_upd       = 1'b0;
    o_addr_new       = addr_inc(r_cur_addr);
    case (r_state)
      StIdle: begin
        if (i_fill_start && (i_fill_count != '0)) begin
          w_state_next     = StFill;
          w_cur_addr_next  = i_pixel_addr;
          w_remaining_next = i_fill_count;
        end else if (i_pix_wr) begin
          w_wr       = 1'b1;
          w_wr_addr  = i_pixel_addr;
          w_wr_data  = i_pixel_data;
          o_addr_upd = i_auto_inc;
          o_addr_new = addr_inc(i_pixel_addr);
        end
      end
      StFill: begin
        w_wr             = 1'b1;
        w_cur_addr_next  = addr_inc(r_cur_addr);
        w_remaining_next = r_remaining - CW'(1);
        // Last pixel: hand the post-fill address back to PIXEL_ADDR.
        if (r_remaining == CW'(1)) begin
          w_state_next = StIdle;
          o_addr_upd   = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_fbuf_en   <= 1'b0;
      r_fbuf_addr <= '0;
      r_fbuf_data <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cur_addr  <= w_cur_addr_next;
      r_remaining <= w_remaining_next;
      r_fbuf_en   <= w_wr;
      if (w_wr) begin
        r_fbuf_addr <= w_wr_addr;
        r_fbuf_data <= w_wr_data;
      end
    end
  end

  assign o_busy      = (r_state == StFill);
  assign o_fbuf_en   = r_fbuf_en;
  assign o_fbuf_we   = r_fbuf_en;
  assign o_fbuf_addr = r_fbuf_addr;
  assign o_fbuf_data = r_fbuf_data;

endmodule

// File: rtl/axi4_lite_gpu_ctrl.sv
// AXI4-Lite control slave for the framebuffer path: register map, single outstanding write,
// registered read channel, and the fill engine driving the BRAM write port.
module axi4_lite_gpu_ctrl
  import gpu_ctrl_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH    = 32,
  parameter int unsigned FBUF_ADDR_WIDTH   = 19,
  parameter int unsigned FBUF_DATA_WIDTH   = 8,
  parameter int unsigned FBUF_DEPTH        = 307200
) (
  input  logic                          s_axi_ctrl_aclk,
  input  logic                          s_axi_ctrl_aresetn,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  s_axi_ctrl_araddr,
  input  logic                          s_axi_ctrl_arvalid,
  output logic                          s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
  output logic [1:0]                    s_axi_ctrl_rresp,
  output logic                          s_axi_ctrl_rvalid,
  input  logic                          s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  s_axi_ctrl_awaddr,
  input  logic                          s_axi_ctrl_awvalid,
  output logic                          s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
  input  logic                          s_axi_ctrl_wvalid,
  output logic                          s_axi_ctrl_wready,
  output logic [1:0]                    s_axi_ctrl_bresp,
  output logic                          s_axi_ctrl_bvalid,
  input  logic                          s_axi_ctrl_bready,
  output logic                          fbuf_en_wr,
  output logic                          fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]    fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]    fbuf_data
);

  localparam int unsigned FA = FBUF_ADDR_WIDTH;

  logic        r_awready, r_aw_full, r_wready, r_w_full;
  logic [2:0]  r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic        r_auto_inc, r_err;
  logic [FA-1:0] r_pixel_addr;
  logic [FA:0]   r_fill_count;
  logic [31:0]   r_fill_color;

  logic        w_exec, w_busy, w_start_req, w_b_hs, w_ar_hs, w_rvalid_next;
  logic        w_wr_err, w_rd_err, w_fill_start, w_pix_wr, w_ctrl_we, w_err_clr;
  logic        w_pa_we, w_fc_we, w_fcol_we, w_addr_upd;
  logic [FA-1:0] w_addr_new;
  logic [31:0] w_pa_merged, w_fc_merged, w_fcol_merged, w_rd_data;
  logic        w_unused_addr;

  assign w_unused_addr = ^{s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_awaddr[1:0],
                           s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_araddr[1:0],
                           w_fc_merged[31:FA+1]};

  assign w_exec        = r_aw_full && r_w_full && !r_bvalid;
  assign w_b_hs        = r_bvalid && s_axi_ctrl_bready;
  assign w_start_req   = r_wstrb[0] && r_wdata[CTRL_FILL_START_BIT];
  assign w_pa_merged   = strb_merge(32'(r_pixel_addr), r_wdata, r_wstrb);
  assign w_fc_merged   = strb_merge(32'(r_fill_count), r_wdata, r_wstrb);
  assign w_fcol_merged = strb_merge(r_fill_color, r_wdata, r_wstrb);

  always_comb begin
    w_wr_err     = 1'b0;
    w_fill_start = 1'b0;
    w_pix_wr     = 1'b0;
    w_ctrl_we    = 1'b0;
    w_err_clr    = 1'b0;
    w_pa_we      = 1'b0;
    w_fc_we      = 1'b0;
    w_fcol_we    = 1'b0;
    if (w_exec) begin
      case (r_aw_idx)
        ADDR_CTRL: begin
          if (w_start_req && w_busy) begin
            w_wr_err = 1'b1;
          end else begin
            w_ctrl_we    = r_wstrb[0];
            w_fill_start = w_start_req;
          end
        end
        ADDR_STATUS:     w_err_clr = r_wstrb[0] && r_wdata[STATUS_ERR_BIT];
        ADDR_PIXEL_ADDR: begin
          if (w_busy || (w_pa_merged >= 32'(FBUF_DEPTH))) w_wr_err = 1'b1;
          else                                            w_pa_we  = 1'b1;
        end
        ADDR_PIXEL_DATA: begin
          if (w_busy || !r_wstrb[0]) w_wr_err = 1'b1;
          else                       w_pix_wr = 1'b1;
        end
        ADDR_FILL_COUNT: begin
          if (w_busy) w_wr_err = 1'b1;
          else        w_fc_we  = 1'b1;
        end
        ADDR_FILL_COLOR: begin
          if (w_busy) w_wr_err  = 1'b1;
          else        w_fcol_we = 1'b1;
        end
        default: w_wr_err = 1'b1;
      endcase
    end
  end

  assign w_ar_hs = s_axi_ctrl_arvalid && r_arready;

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (s_axi_ctrl_araddr[4:2])
      ADDR_CTRL:       w_rd_data[CTRL_AUTO_INC_BIT] = r_auto_inc;
      ADDR_STATUS: begin
        w_rd_data[STATUS_BUSY_BIT] = w_busy;
        w_rd_data[STATUS_ERR_BIT]  = r_err;
      end
      ADDR_PIXEL_ADDR: w_rd_data = 32'(r_pixel_addr);
      ADDR_PIXEL_DATA: w_rd_data = '0;
      ADDR_FILL_COUNT: w_rd_data = 32'(r_fill_count);
      ADDR_FILL_COLOR: w_rd_data = r_fill_color;
      default:         w_rd_err  = w_ar_hs;
    endcase
  end

  // arready tracks !rvalid one edge late so it also comes out of reset low.
  assign w_rvalid_next = w_ar_hs ? 1'b1 : ((r_rvalid && s_axi_ctrl_rready) ? 1'b0 : r_rvalid);

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      r_awready    <= 1'b0;
      r_aw_full    <= 1'b0;
      r_aw_idx     <= '0;
      r_wready     <= 1'b0;
      r_w_full     <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
      r_auto_inc   <= 1'b0;
      r_err        <= 1'b0;
      r_pixel_addr <= '0;
      r_fill_count <= '0;
      r_fill_color <= '0;
    end else begin
      r_awready <= s_axi_ctrl_awvalid && !r_aw_full && !r_awready;
      r_wready  <= s_axi_ctrl_wvalid && !r_w_full && !r_wready;
      if (w_b_hs) begin
        r_aw_full <= 1'b0;
      end else if (s_axi_ctrl_awvalid && r_awready) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi_ctrl_awaddr[4:2];
      end
      if (w_b_hs) begin
        r_w_full <= 1'b0;
      end else if (s_axi_ctrl_wvalid && r_wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_ctrl_wdata[31:0];
        r_wstrb  <= s_axi_ctrl_wstrb[3:0];
      end
      if (w_exec) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end

      r_arready <= !w_rvalid_next;
      r_rvalid  <= w_rvalid_next;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end

      r_err <= (r_err && !w_err_clr) || w_wr_err || w_rd_err;
      if (w_ctrl_we) r_auto_inc <= r_wdata[CTRL_AUTO_INC_BIT];
      if (w_pa_we) begin
        r_pixel_addr <= w_pa_merged[FA-1:0];
      end else if (w_addr_upd) begin
        r_pixel_addr <= w_addr_new;
      end
      if (w_fc_we)   r_fill_count <= w_fc_merged[FA:0];
      if (w_fcol_we) r_fill_color <= w_fcol_merged;
    end
  end

  gpu_fill_engine #(
    .FBUF_ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .FBUF_DATA_WIDTH (FBUF_DATA_WIDTH),
    .FBUF_DEPTH      (FBUF_DEPTH)
  ) u_fill_engine (
    .i_clk        (s_axi_ctrl_aclk),
    .i_rst_n      (s_axi_ctrl_aresetn),
    .i_fill_start (w_fill_start),
    .i_pix_wr     (w_pix_wr),
    .i_auto_inc   (r_auto_inc),
    .i_pixel_addr (r_pixel_addr),
    .i_pixel_data (r_wdata[FBUF_DATA_WIDTH-1:0]),
    .i_fill_color (r_fill_color[FBUF_DATA_WIDTH-1:0]),
    .i_fill_count (r_fill_count),
    .o_busy       (w_busy),
    .o_addr_upd   (w_addr_upd),
    .o_addr_new   (w_addr_new),
    .o_fbuf_en    (fbuf_en_wr),
    .o_fbuf_we    (fbuf_wrea),
    .o_fbuf_addr  (fbuf_addr),
    .o_fbuf_data  (fbuf_data)
  );

  assign s_axi_ctrl_awready = r_awready;
  assign s_axi_ctrl_wready  = r_wready;
  assign s_axi_ctrl_bvalid  = r_bvalid;
  assign s_axi_ctrl_bresp   = r_bresp;
  assign s_axi_ctrl_arready = r_arready;
  assign s_axi_ctrl_rvalid  = r_rvalid;
  assign s_axi_ctrl_rresp   = r_rresp;
  assign s_axi_ctrl_rdata   = AXI_DATA_WIDTH'(r_rdata);

endmodule

// File: tb/tb_axi4_lite_gpu_ctrl.sv
// Directed bench: register-map vector table, then hand sequences for pixel writes,
// wrap, fills, busy rejection and asynchronous reset mid-fill.
module tb_axi4_lite_gpu_ctrl;

  localparam int unsigned DEPTH = 307200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  always #5 clk = ~clk;

  axi4_lite_gpu_ctrl dut (
    .s_axi_ctrl_aclk    (clk),
    .s_axi_ctrl_aresetn (rst_n),
    .s_axi_ctrl_araddr  (araddr),
    .s_axi_ctrl_arvalid (arvalid),
    .s_axi_ctrl_arready (arready),
    .s_axi_ctrl_rdata   (rdata),
    .s_axi_ctrl_rresp   (rresp),
    .s_axi_ctrl_rvalid  (rvalid),
    .s_axi_ctrl_rready  (rready),
    .s_axi_ctrl_awaddr  (awaddr),
    .s_axi_ctrl_awvalid (awvalid),
    .s_axi_ctrl_awready (awready),
    .s_axi_ctrl_wdata   (wdata),
    .s_axi_ctrl_wstrb   (wstrb),
    .s_axi_ctrl_wvalid  (wvalid),
    .s_axi_ctrl_wready  (wready),
    .s_axi_ctrl_bresp   (bresp),
    .s_axi_ctrl_bvalid  (bvalid),
    .s_axi_ctrl_bready  (bready),
    .fbuf_en_wr         (fbuf_en_wr),
    .fbuf_wrea          (fbuf_wrea),
    .fbuf_addr          (fbuf_addr),
    .fbuf_data          (fbuf_data)
  );

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
    logic [31:0] cyc;
  } bram_wr_t;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  bram_wr_t    wq[$];
  vec_t        vq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] cyc = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fbuf_en_wr && fbuf_wrea) wq.push_back('{fbuf_addr, fbuf_data, cyc});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic send_aw(input logic [31:0] a);
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 50 && !awready; n++) @(negedge clk);
    if (!awready) timeout("awready");
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 50 && !wready; n++) @(negedge clk);
    if (!wready) timeout("wready");
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit w_first, input int gap, input int bhold, input bit skip_b,
                           output logic [1:0] resp);
    resp = 2'bxx;
    if (w_first) begin
      send_w(d, s);
      repeat (gap) @(negedge clk);
      send_aw(a);
    end else begin
      send_aw(a);
      repeat (gap) @(negedge clk);
      send_w(d, s);
    end
    for (int n = 0; n < 50 && !bvalid; n++) @(negedge clk);
    if (!bvalid) begin
      timeout("bvalid");
      return;
    end
    resp = bresp;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
    end
    if (skip_b) return;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    axi_write(a, d, 4'hF, 1'b0, 0, 0, 1'b0, resp);
  endtask

  task automatic axi_read(input logic [31:0] a, input bit hold, output logic [31:0] d,
                          output logic [1:0] r);
    d = 'x;
    r = 'x;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) @(negedge clk);
    if (!arready) begin
      timeout("arready");
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    for (int n = 0; n < 50 && !rvalid; n++) @(negedge clk);
    if (!rvalid) begin
      timeout("rvalid");
      return;
    end
    d = rdata;
    r = rresp;
    if (hold) return;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, 1'b0, d, r);
    chk({nm, "_rresp"}, 32'(r), 32'(2'b00));
    chk(nm, d, exp);
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 60; i++) begin
      axi_read(32'h04, 1'b0, d, r);
      if (d[0] == 1'b0) return;
    end
    timeout(nm);
  endtask

  task automatic addv(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] er, input logic [31:0] ed);
    vq.push_back('{w, a, d, s, er, ed});
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [1:0]  r;
    int          base, mism, snap;

    addv(0, 32'h00, 0, 0, 2'b00, 32'h0);
    addv(0, 32'h04, 0, 0, 2'b00, 32'h0);
    addv(0, 32'h08, 0, 0, 2'b00, 32'h0);
    addv(0, 32'h10, 0, 0, 2'b00, 32'h0);
    addv(0, 32'h14, 0, 0, 2'b00, 32'h0);
    addv(1, 32'h14, 32'h11223344, 4'hF, 2'b00, 0);
    addv(1, 32'h14, 32'hAABBCCDD, 4'h2, 2'b00, 0);
    addv(0, 32'h14, 0, 0, 2'b00, 32'h1122CC44);
    addv(0, 32'h18, 0, 0, 2'b10, 32'h0);
    addv(0, 32'h04, 0, 0, 2'b00, 32'h2);
    addv(1, 32'h04, 32'h2, 4'h1, 2'b00, 0);
    addv(0, 32'h04, 0, 0, 2'b00, 32'h0);
    addv(1, 32'h08, 32'd400000, 4'hF, 2'b10, 0);
    addv(0, 32'h08, 0, 0, 2'b00, 32'h0);
    addv(1, 32'h08, 32'd307200, 4'hF, 2'b10, 0);
    addv(1, 32'h08, 32'd307199, 4'hF, 2'b00, 0);
    addv(0, 32'h08, 0, 0, 2'b00, 32'h0004AFFF);
    addv(0, 32'h28, 0, 0, 2'b00, 32'h0004AFFF);
    addv(1, 32'h08, 32'h12345678, 4'h1, 2'b00, 0);
    addv(0, 32'h08, 0, 0, 2'b00, 32'h0004AF78);
    addv(1, 32'h1C, 32'h0, 4'hF, 2'b10, 0);
    addv(1, 32'h0C, 32'h5A, 4'hE, 2'b10, 0);
    addv(0, 32'h0C, 0, 0, 2'b00, 32'h0);
    addv(1, 32'h00, 32'h3, 4'hF, 2'b00, 0);
    addv(0, 32'h00, 0, 0, 2'b00, 32'h2);
    addv(0, 32'h04, 0, 0, 2'b00, 32'h2);
    addv(1, 32'h04, 32'h2, 4'h1, 2'b00, 0);
    addv(1, 32'h10, 32'hFFFFFFFF, 4'h1, 2'b00, 0);
    addv(0, 32'h10, 0, 0, 2'b00, 32'hFF);
    addv(1, 32'h10, 32'h0, 4'hF, 2'b00, 0);
    addv(1, 32'h00, 32'h0, 4'hF, 2'b00, 0);
    addv(0, 32'h00, 0, 0, 2'b00, 32'h0);

    repeat (3) @(negedge clk);
    chk("rst_fbuf_en", 32'(fbuf_en_wr), 0);
    chk("rst_ready", {29'b0, arready, awready, wready}, 0);
    chk("rst_valid", {30'b0, bvalid, rvalid}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].is_wr) begin
        axi_write(vq[i].addr, vq[i].data, vq[i].strb, 1'b0, 0, 0, 1'b0, resp);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vq[i].exp_resp));
      end else begin
        axi_read(vq[i].addr, 1'b0, d, r);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vq[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), d, vq[i].exp_rdata);
      end
    end
    chk("vec_no_bram", wq.size(), 0);

    // Single pixel, AW first then W three cycles later, bready held low four cycles.
    base = wq.size();
    wr(32'h08, 32'h10, resp);
    axi_write(32'h0C, 32'hA5, 4'hF, 1'b0, 3, 4, 1'b0, resp);
    chk("pix_bresp", 32'(resp), 0);
    chk("pix_count", wq.size() - base, 1);
    if (wq.size() > base) begin
      chk("pix_addr", 32'(wq[base].a), 32'h10);
      chk("pix_data", 32'(wq[base].d), 32'hA5);
    end
    rd_chk("pix_pa_noinc", 32'h08, 32'h10);

    // Auto-increment across the wrap point; one write with W ahead of AW.
    base = wq.size();
    wr(32'h00, 32'h2, resp);
    wr(32'h08, 32'd307199, resp);
    axi_write(32'h0C, 32'h01, 4'h1, 1'b1, 2, 0, 1'b0, resp);
    chk("inc_bresp", 32'(resp), 0);
    wr(32'h0C, 32'h02, resp);
    chk("inc_count", wq.size() - base, 2);
    if (wq.size() >= base + 2) begin
      chk("inc_w0", {5'b0, wq[base].a, wq[base].d}, {5'b0, 19'd307199, 8'h01});
      chk("inc_w1", {5'b0, wq[base+1].a, wq[base+1].d}, {5'b0, 19'd0, 8'h02});
    end
    rd_chk("inc_pa", 32'h08, 32'd1);

    // Five-pixel fill wrapping through zero.
    base = wq.size();
    wr(32'h14, 32'h3C, resp);
    wr(32'h10, 32'd5, resp);
    wr(32'h08, 32'd307197, resp);
    wr(32'h00, 32'h1, resp);
    chk("fill5_bresp", 32'(resp), 0);
    rd_chk("fill5_busy", 32'h04, 32'h1);
    repeat (10) @(negedge clk);
    rd_chk("fill5_idle", 32'h04, 32'h0);
    chk("fill5_count", wq.size() - base, 5);
    if (wq.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("fill5_addr%0d", i), 32'(wq[base+i].a), (32'd307197 + i) % DEPTH);
        chk($sformatf("fill5_data%0d", i), 32'(wq[base+i].d), 32'h3C);
        if (i > 0) chk($sformatf("fill5_cyc%0d", i), wq[base+i].cyc - wq[base+i-1].cyc, 1);
      end
    end
    rd_chk("fill5_pa", 32'h08, 32'd2);

    // Hundred-pixel fill with a rejected pixel write and a read that must not stall.
    base = wq.size();
    wr(32'h10, 32'd100, resp);
    wr(32'h00, 32'h1, resp);
    wr(32'h0C, 32'h77, resp);
    chk("busy_pix_bresp", 32'(resp), 32'(2'b10));
    rd_chk("busy_fc", 32'h10, 32'd100);
    rd_chk("busy_status", 32'h04, 32'h3);
    wait_idle("fill100_done");
    chk("fill100_count", wq.size() - base, 100);
    mism = 0;
    for (int i = base; i < wq.size(); i++) if (wq[i].d != 8'h3C) mism++;
    chk("fill100_colour", mism, 0);
    if (wq.size() > base) chk("fill100_last", 32'(wq[wq.size()-1].a), 32'd101);
    rd_chk("fill100_pa", 32'h08, 32'd102);
    rd_chk("fill100_err", 32'h04, 32'h2);

    // Asynchronous reset in the middle of a 50-pixel fill.
    base = wq.size();
    wr(32'h10, 32'd50, resp);
    wr(32'h00, 32'h1, resp);
    for (int n = 0; n < 200 && (wq.size() - base) < 20; n++) @(negedge clk);
    axi_read(32'h04, 1'b1, d, r);
    axi_write(32'h0C, 32'h55, 4'hF, 1'b0, 0, 0, 1'b1, resp);
    chk("mid_fbuf_en", 32'(fbuf_en_wr), 1);
    chk("mid_valid", {30'b0, bvalid, rvalid}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fbuf_en", {30'b0, fbuf_en_wr, fbuf_wrea}, 0);
    chk("arst_valid", {30'b0, bvalid, rvalid}, 0);
    snap = wq.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("arst_no_bram", wq.size() - snap, 0);
    rd_chk("arst_ctrl", 32'h00, 0);
    rd_chk("arst_status", 32'h04, 0);
    rd_chk("arst_pa", 32'h08, 0);
    rd_chk("arst_fc", 32'h10, 0);
    rd_chk("arst_fcol", 32'h14, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
